// File: rtl/dac_output_mixer.sv
// dac_output_mixer: per-channel DDS/custom-waveform source selection with
// click-free ramped switchover, followed by gain, envelope, offset and
// saturation, producing 14-bit offset-binary DAC codes.

// One output channel: envelope state machine plus a 4-stage datapath.
module dac_mixer_channel #(
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic signed [13:0] dds_data,
  input  logic signed [13:0] wave_data,
  input  logic               wave_active,
  input  logic        [8:0]  gain,
  input  logic signed [13:0] offset,
  output logic        [13:0] dac_code,
  output logic               src_sel,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DOWN,
    S_SWAP,
    S_UP
  } state_t;

  localparam logic [9:0] STEP    = 10'(RAMP_STEP);
  localparam logic [8:0] ENV_MAX = 9'd256;

  state_t     state, state_nxt;
  logic [8:0] env, env_nxt;
  logic       cur_src, cur_src_nxt;
  logic [9:0] env_up;

  // Envelope/source control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_RUN;
      env     <= ENV_MAX;
      cur_src <= 1'b0;
    end else begin
      state   <= state_nxt;
      env     <= env_nxt;
      cur_src <= cur_src_nxt;
    end
  end

  // Next-state logic: ramp down, swap at zero envelope, ramp back up.
  // A reversal in S_DOWN/S_UP leaves env untouched so the output has no step.
  always_comb begin
    state_nxt   = state;
    env_nxt     = env;
    cur_src_nxt = cur_src;
    env_up      = {1'b0, env} + STEP;
    case (state)
      S_RUN: begin
        if (wave_active != cur_src) state_nxt = S_DOWN;
      end
      S_DOWN: begin
        if (wave_active == cur_src) begin
          state_nxt = S_UP;
        end else if (env == '0) begin
          state_nxt = S_SWAP;
        end else if (tick) begin
          env_nxt = ({1'b0, env} <= STEP) ? '0 : env - STEP[8:0];
        end
      end
      S_SWAP: begin
        cur_src_nxt = wave_active;
        state_nxt   = S_UP;
      end
      S_UP: begin
        if (wave_active != cur_src) begin
          state_nxt = S_DOWN;
        end else if (env == ENV_MAX) begin
          state_nxt = S_RUN;
        end else if (tick) begin
          env_nxt = (env_up >= {1'b0, ENV_MAX}) ? ENV_MAX : env_up[8:0];
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  assign src_sel = cur_src;
  assign busy    = (state != S_RUN);

  logic signed [13:0] smp_r;
  logic        [8:0]  env1_r;
  logic signed [13:0] g_r;
  logic        [8:0]  env2_r;
  logic signed [13:0] e_r;
  logic        [13:0] code_r;

  logic signed [23:0] gain_prod, gain_shr, env_prod;
  logic signed [13:0] g_sat, e_val, s_sat;
  logic signed [14:0] sum;

  // Datapath arithmetic: gain with saturation, envelope scaling, offset clamp.
  always_comb begin
    gain_prod = 24'(smp_r) * 24'($signed({1'b0, gain}));
    gain_shr  = gain_prod >>> 8;
    if (gain_shr > 24'sd8191)       g_sat = 14'sh1FFF;
    else if (gain_shr < -24'sd8192) g_sat = 14'sh2000;
    else                            g_sat = 14'(gain_shr);

    // |g * env / 256| never exceeds |g| since env <= 256, so truncation is exact.
    env_prod = 24'(g_r) * 24'($signed({1'b0, env2_r}));
    e_val    = 14'(env_prod >>> 8);

    sum = 15'(e_r) + 15'(offset);
    if (sum > 15'sd8191)       s_sat = 14'sh1FFF;
    else if (sum < -15'sd8192) s_sat = 14'sh2000;
    else                       s_sat = 14'(sum);
  end

  // Four pipeline stages: select, gain, envelope, offset/convert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_r  <= '0;
      env1_r <= '0;
      g_r    <= '0;
      env2_r <= '0;
      e_r    <= '0;
      code_r <= 14'h2000;
    end else begin
      smp_r  <= cur_src ? wave_data : dds_data;
      env1_r <= env;
      g_r    <= g_sat;
      env2_r <= env1_r;
      e_r    <= e_val;
      code_r <= s_sat ^ 14'h2000;
    end
  end

  assign dac_code = code_r;

endmodule

// Top level: shared ramp prescaler and two independent channels.
module dac_output_mixer #(
  parameter int unsigned RAMP_DIV  = 4,
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] dds_data_a,
  input  logic [13:0] dds_data_b,
  input  logic [13:0] wave_data_a,
  input  logic [13:0] wave_data_b,
  input  logic        wave_active_a,
  input  logic        wave_active_b,
  input  logic [8:0]  gain_a,
  input  logic [8:0]  gain_b,
  input  logic [13:0] offset_a,
  input  logic [13:0] offset_b,
  output logic [13:0] dac_code_a,
  output logic [13:0] dac_code_b,
  output logic        src_sel_a,
  output logic        src_sel_b,
  output logic        busy_a,
  output logic        busy_b
);

  localparam int unsigned    CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  // Free-running prescaler counting 0..RAMP_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (cnt == CNT_LAST)  cnt <= '0;
    else                       cnt <= cnt + CNT_W'(1);
  end

  assign tick = (cnt == CNT_LAST);

  dac_mixer_channel #(.RAMP_STEP(RAMP_STEP)) u_chan_a (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .dds_data    (dds_data_a),
    .wave_data   (wave_data_a),
    .wave_active (wave_active_a),
    .gain        (gain_a),
    .offset      (offset_a),
    .dac_code    (dac_code_a),
    .src_sel     (src_sel_a),
    .busy        (busy_a)
  );

  dac_mixer_channel #(.RAMP_STEP(RAMP_STEP)) u_chan_b (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .dds_data    (dds_data_b),
    .wave_data   (wave_data_b),
    .wave_active (wave_active_b),
    .gain        (gain_b),
    .offset      (offset_b),
    .dac_code    (dac_code_b),
    .src_sel     (src_sel_b),
    .busy        (busy_b)
  );

endmodule

// File: tb/tb_dac_output_mixer.sv
// Testbench for dac_output_mixer: scoreboard for pipelined codes plus
// directed checks on the switchover, abort and reset-mid-ramp behaviour.
module tb_dac_output_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] dds_data_a = '0, dds_data_b = '0;
  logic [13:0] wave_data_a = '0, wave_data_b = '0;
  logic        wave_active_a = 1'b0, wave_active_b = 1'b0;
  logic [8:0]  gain_a = 9'd256, gain_b = 9'd256;
  logic [13:0] offset_a = '0, offset_b = '0;
  logic [13:0] dac_code_a, dac_code_b;
  logic        src_sel_a, src_sel_b, busy_a, busy_b;

  dac_output_mixer #(.RAMP_DIV(4), .RAMP_STEP(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .dds_data_a    (dds_data_a),
    .dds_data_b    (dds_data_b),
    .wave_data_a   (wave_data_a),
    .wave_data_b   (wave_data_b),
    .wave_active_a (wave_active_a),
    .wave_active_b (wave_active_b),
    .gain_a        (gain_a),
    .gain_b        (gain_b),
    .offset_a      (offset_a),
    .offset_b      (offset_b),
    .dac_code_a    (dac_code_a),
    .dac_code_b    (dac_code_b),
    .src_sel_a     (src_sel_a),
    .src_sel_b     (src_sel_b),
    .busy_a        (busy_a),
    .busy_b        (busy_b)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned due;
    bit          ch;
    logic [13:0] exp;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Queue an expected code for a channel, due d cycles from now.
  task automatic expect_code(input int unsigned d, input bit ch, input logic [13:0] exp,
                             input string name);
    sbq.push_back('{cyc + d, ch, exp, name});
  endtask

  // Monitor: compares the DUT output whenever a queued expectation falls due.
  always @(negedge clk) begin
    if (!reset) begin
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        mon_e = sbq.pop_front();
        if (mon_e.due < cyc) check({mon_e.name, "_late"}, cyc, mon_e.due);
        else check(mon_e.name, mon_e.ch ? dac_code_b : dac_code_a, mon_e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int vec_d[9] = '{8191, -8192, 8000, -8000, 3000, -3, -1, 1, -1};
  int vec_g[9] = '{511, 511, 256, 256, 128, 256, 1, 1, 256};
  int vec_o[9] = '{0, 0, 1000, -1000, -500, 0, 0, 0, -8192};
  int vec_e[9] = '{'h3FFF, 'h0000, 'h3FFF, 'h0000, 'h23E8, 'h1FFD, 'h1FFF, 'h2000, 'h0000};

  logic [13:0] prev, minc;
  int          n, d, maxstep, src_rise_n, hit_n;
  bit          src_ok, b_ok, mono_ok, neg_ok;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_code_a", dac_code_a, 14'h2000);
    check("rst_code_b", dac_code_b, 14'h2000);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_src_a", src_sel_a, 1'b0);
    check("rst_src_b", src_sel_b, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Unity path with latency check
    dds_data_a = 14'd1000;
    dds_data_b = 14'(-1000);
    expect_code(3, 1'b0, 14'h2000, "latency_a");
    expect_code(4, 1'b0, 14'h23E8, "unity_a");
    expect_code(4, 1'b1, 14'h1C18, "unity_b");
    repeat (6) @(negedge clk);

    // Gain/offset saturation and flooring vectors
    for (int i = 0; i < 9; i++) begin
      dds_data_a = 14'(vec_d[i]);
      gain_a     = 9'(vec_g[i]);
      offset_a   = 14'(vec_o[i]);
      expect_code(4, 1'b0, 14'(vec_e[i]), $sformatf("sat%0d", i));
      repeat (5) @(negedge clk);
    end

    // Switchover setup
    gain_a      = 9'd256;
    offset_a    = '0;
    dds_data_a  = 14'd4000;
    wave_data_a = 14'(-4000);
    dds_data_b  = 14'd2000;
    wave_data_b = 14'(-2000);
    repeat (6) @(negedge clk);
    check("pre_code_a", dac_code_a, 14'h2FA0);
    check("pre_code_b", dac_code_b, 14'h27D0);

    // Abort: raise claim, then drop it partway through the ramp down
    wave_active_a = 1'b1;
    @(negedge clk);
    check("abort_busy_rise", busy_a, 1'b1);
    prev = dac_code_a; minc = dac_code_a; maxstep = 0; src_ok = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      d = int'(dac_code_a) - int'(prev);
      if (d < 0) d = -d;
      if (d > maxstep) maxstep = d;
      if (dac_code_a < minc) minc = dac_code_a;
      if (src_sel_a) src_ok = 1'b0;
      prev = dac_code_a;
    end
    wave_active_a = 1'b0;
    n = 0;
    while (busy_a && n < 200) begin
      @(negedge clk);
      n++;
      d = int'(dac_code_a) - int'(prev);
      if (d < 0) d = -d;
      if (d > maxstep) maxstep = d;
      if (dac_code_a < minc) minc = dac_code_a;
      if (src_sel_a) src_ok = 1'b0;
      prev = dac_code_a;
    end
    check("abort_busy_fall", busy_a, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_src_stays_dds", src_ok, 1'b1);
    check("abort_no_step", maxstep <= 260, 1'b1);
    check("abort_dipped", minc < 14'h2FA0, 1'b1);
    check("abort_not_zero", minc > 14'h2000, 1'b1);
    check("abort_final", dac_code_a, 14'h2FA0);

    // Full switchover to the custom source
    wave_active_a = 1'b1;
    prev = dac_code_a; n = 0; maxstep = 0; src_rise_n = -1; hit_n = -1;
    b_ok = 1'b1; mono_ok = 1'b1; neg_ok = 1'b1;
    @(negedge clk);
    n++;
    check("sw_busy_rise", busy_a, 1'b1);
    while (busy_a && n < 200) begin
      @(negedge clk);
      n++;
      if (dac_code_a > prev) mono_ok = 1'b0;
      d = int'(prev) - int'(dac_code_a);
      if (d > maxstep) maxstep = d;
      if (!src_sel_a && dac_code_a < 14'h2000) neg_ok = 1'b0;
      if (src_sel_a && src_rise_n < 0) src_rise_n = n;
      if (src_rise_n >= 0 && hit_n < 0 && dac_code_a == 14'h2000) hit_n = n;
      if (dac_code_b !== 14'h27D0 || busy_b || src_sel_b) b_ok = 1'b0;
      prev = dac_code_a;
    end
    check("sw_busy_within_133", n <= 133, 1'b1);
    repeat (5) @(negedge clk);
    if (dac_code_a > prev) mono_ok = 1'b0;
    check("sw_monotonic", mono_ok, 1'b1);
    check("sw_no_step", maxstep <= 260, 1'b1);
    check("sw_no_neg_before_swap", neg_ok, 1'b1);
    check("sw_src_rose", src_rise_n > 0, 1'b1);
    check("sw_zero_at_swap", (hit_n >= src_rise_n) && (hit_n - src_rise_n <= 4), 1'b1);
    check("sw_final_code", dac_code_a, 14'h1060);
    check("sw_final_src", src_sel_a, 1'b1);
    check("sw_chan_b_untouched", b_ok, 1'b1);

    // Reset during S_UP of the return to DDS
    wave_active_a = 1'b0;
    n = 0;
    while (src_sel_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_src_back", src_sel_a, 1'b0);
    repeat (10) @(negedge clk);
    check("mid_still_ramping", busy_a, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_code_a", dac_code_a, 14'h2000);
    check("mid_rst_code_b", dac_code_b, 14'h2000);
    check("mid_rst_busy_a", busy_a, 1'b0);
    check("mid_rst_src_a", src_sel_a, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    expect_code(3, 1'b0, 14'h2000, "post_rst_fill_a");
    expect_code(4, 1'b0, 14'h2FA0, "post_rst_code_a");
    expect_code(4, 1'b1, 14'h27D0, "post_rst_code_b");
    @(negedge clk);
    check("post_rst_busy_a", busy_a, 1'b0);
    check("post_rst_src_a", src_sel_a, 1'b0);
    repeat (8) @(negedge clk);
    check("sb_drained", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
